// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with in-order line refill
// Lookup runs the cycle after acceptance on the latched address; misses refill a whole line.
module icache_dm #(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_req_valid_i,
   input  logic        icache_wen_i,
   input  logic [31:0] icache_addr_i,
   input  logic        flush_i,
   output logic        icache_ready_o,
   output logic        icache_data_valid_o,
   output logic [31:0] icache_data_o,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rdata_valid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, MREQ, FILL, RESP} state_t;

   state_t             state_q, state_d;
   logic               pend_q, pend_d;
   logic [31:2]        addr_q, addr_d;
   logic [OFF_W-1:0]   beat_q, beat_d;
   logic               fseen_q, fseen_d;
   logic [LINES-1:0]   valid_q, valid_d;

   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES*LINE_WORDS];

   logic [TAG_W-1:0]   req_tag;
   logic [IDX_W-1:0]   req_idx;
   logic [OFF_W-1:0]   req_off;
   logic               hit;
   logic [31:0]        rd_word;
   logic               ready_c, dv_c, mreq_c, fill_we, tag_we;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^icache_addr_i[1:0];

   assign req_off = addr_q[OFF_W+1:2];
   assign req_idx = addr_q[IDX_W+OFF_W+1:OFF_W+2];
   assign req_tag = addr_q[31:32-TAG_W];
   assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign rd_word = data_mem[{req_idx, req_off}];

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      fseen_d = fseen_q;
      valid_d = valid_q;
      ready_c = 1'b0;
      dv_c    = 1'b0;
      mreq_c  = 1'b0;
      fill_we = 1'b0;
      tag_we  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = !(pend_q && !hit);
            if (pend_q) begin
               if (hit) begin
                  dv_c   = 1'b1;
                  pend_d = 1'b0;
               end else begin
                  state_d = MREQ;
                  fseen_d = 1'b0;
               end
            end
            // Write requests are accepted but never latched.
            if (icache_req_valid_i && ready_c && !icache_wen_i) begin
               addr_d = icache_addr_i[31:2];
               pend_d = 1'b1;
            end
         end
         MREQ: begin
            mreq_c = 1'b1;
            if (mem_req_ready_i) begin
               state_d = FILL;
               beat_d  = '0;
            end
         end
         FILL: begin
            if (mem_rdata_valid_i) begin
               fill_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                  tag_we  = 1'b1;
                  state_d = RESP;
                  if (!fseen_q) valid_d[req_idx] = 1'b1;
               end
            end
         end
         RESP: begin
            dv_c    = 1'b1;
            state_d = IDLE;
            pend_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // A flush anywhere in the refill keeps the line from being validated.
      if (flush_i) begin
         valid_d = '0;
         if (state_q == MREQ || state_q == FILL) fseen_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         addr_q  <= '0;
         beat_q  <= '0;
         fseen_q <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         fseen_q <= fseen_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && fill_we) data_mem[{req_idx, beat_q}] <= mem_rdata_i;
      if (rst && tag_we)  tag_mem[req_idx] <= req_tag;
   end

   assign icache_ready_o      = rst & ready_c;
   assign icache_data_valid_o = rst & dv_c;
   assign icache_data_o       = rst ? rd_word : 32'h0;
   assign mem_req_valid_o     = rst & mreq_c;
   assign mem_addr_o          = rst ? {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}} : 32'h0;

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
// Inputs change just after a negedge; outputs are sampled at negedges.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, wen, flush, mem_req_ready, mem_rvalid;
   logic [31:0] addr, mem_rdata;
   logic        ready, dv, mem_req_valid;
   logic [31:0] data, mem_addr;

   int vec  = 0;
   int errs = 0;

   localparam logic [31:0] A = 32'hA000_0000;
   localparam logic [31:0] B = 32'hB000_0000;
   localparam logic [31:0] C = 32'hC000_0000;
   localparam logic [31:0] D = 32'hD000_0000;
   localparam logic [31:0] E = 32'hE000_0000;
   localparam logic [31:0] X = 32'h5555_0000;

   icache_dm dut (
      .clk                 (clk),
      .rst                 (rst),
      .icache_req_valid_i  (req_valid),
      .icache_wen_i        (wen),
      .icache_addr_i       (addr),
      .flush_i             (flush),
      .icache_ready_o      (ready),
      .icache_data_valid_o (dv),
      .icache_data_o       (data),
      .mem_req_valid_o     (mem_req_valid),
      .mem_req_ready_i     (mem_req_ready),
      .mem_addr_o          (mem_addr),
      .mem_rdata_valid_i   (mem_rvalid),
      .mem_rdata_i         (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic [31:0] a, input logic w);
      req_valid = 1'b1; addr = a; wen = w;
      @(negedge clk);
      req_valid = 1'b0; wen = 1'b0;
   endtask

   task automatic grant(output logic found, output logic [31:0] ma);
      found = 1'b0; ma = '0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (mem_req_valid) begin
            found = 1'b1; ma = mem_addr; mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic beats(input logic [31:0] base, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         mem_rvalid = 1'b1; mem_rdata = base + i;
         @(negedge clk);
         mem_rvalid = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      vec++; if ({ready, dv, mem_req_valid} !== 3'b000) begin errs++; $display("FAIL reset_outs got=%b exp=000", {ready, dv, mem_req_valid}); end
      vec++; if (data !== 32'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", data); end
      rst = 1'b1;
      @(negedge clk);
      vec++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", ready); end
   endtask

   task automatic test_cold_miss;
      logic f; logic [31:0] ma;
      issue(32'h0000_1008, 1'b0);
      vec++; if ({ready, dv} !== 2'b00) begin errs++; $display("FAIL cold_lookup got=%b exp=00", {ready, dv}); end
      grant(f, ma);
      vec++; if (f !== 1'b1) begin errs++; $display("FAIL cold_mreq_timeout got=%b exp=1", f); end
      vec++; if (ma !== 32'h0000_1000) begin errs++; $display("FAIL cold_mem_addr got=%h exp=00001000", ma); end
      beats(A, 0, 3);
      vec++; if ({ready, dv} !== 2'b00) begin errs++; $display("FAIL cold_fill_stall got=%b exp=00", {ready, dv}); end
      beats(A, 3, 1);
      vec++; if ({ready, dv} !== 2'b01) begin errs++; $display("FAIL cold_resp got=%b exp=01", {ready, dv}); end
      vec++; if (data !== A + 2) begin errs++; $display("FAIL cold_data got=%h exp=%h", data, A + 2); end
      @(negedge clk);
      vec++; if ({ready, dv} !== 2'b10) begin errs++; $display("FAIL cold_idle got=%b exp=10", {ready, dv}); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] addrs [3];
      logic [31:0] exp [3];
      addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h100C;
      exp[0] = A; exp[1] = A + 1; exp[2] = A + 3;
      req_valid = 1'b1; wen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         addr = addrs[i];
         @(negedge clk);
         if (i == 2) req_valid = 1'b0;
         vec++; if ({ready, dv, mem_req_valid} !== 3'b110) begin errs++; $display("FAIL hit%0d_flags got=%b exp=110", i, {ready, dv, mem_req_valid}); end
         vec++; if (data !== exp[i]) begin errs++; $display("FAIL hit%0d_data got=%h exp=%h", i, data, exp[i]); end
      end
      @(negedge clk);
      vec++; if (dv !== 1'b0) begin errs++; $display("FAIL hit_done_dv got=%b exp=0", dv); end
   endtask

   task automatic test_conflict;
      logic f; logic [31:0] ma;
      issue(32'h0000_1400, 1'b0);
      vec++; if (ready !== 1'b0) begin errs++; $display("FAIL conf_miss got=%b exp=0", ready); end
      grant(f, ma);
      vec++; if (ma !== 32'h0000_1400) begin errs++; $display("FAIL conf_mem_addr got=%h exp=00001400", ma); end
      beats(B, 0, 4);
      vec++; if (dv !== 1'b1 || data !== B) begin errs++; $display("FAIL conf_resp got=%b/%h exp=1/%h", dv, data, B); end
      @(negedge clk);
      issue(32'h0000_1000, 1'b0);
      vec++; if ({ready, dv} !== 2'b00) begin errs++; $display("FAIL conf_remiss got=%b exp=00", {ready, dv}); end
      grant(f, ma);
      vec++; if (ma !== 32'h0000_1000) begin errs++; $display("FAIL conf_remiss_addr got=%h exp=00001000", ma); end
      beats(A, 0, 4);
      vec++; if (dv !== 1'b1 || data !== A) begin errs++; $display("FAIL conf_refill got=%b/%h exp=1/%h", dv, data, A); end
      @(negedge clk);
   endtask

   task automatic test_flush;
      logic f; logic [31:0] ma;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      issue(32'h0000_1004, 1'b0);
      vec++; if ({ready, dv} !== 2'b00) begin errs++; $display("FAIL flush_miss got=%b exp=00", {ready, dv}); end
      grant(f, ma);
      vec++; if (ma !== 32'h0000_1000) begin errs++; $display("FAIL flush_mem_addr got=%h exp=00001000", ma); end
      beats(A, 0, 4);
      vec++; if (dv !== 1'b1 || data !== A + 1) begin errs++; $display("FAIL flush_resp got=%b/%h exp=1/%h", dv, data, A + 1); end
      @(negedge clk);
      issue(32'h0000_2018, 1'b0);
      grant(f, ma);
      beats(C, 0, 2);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      beats(C, 2, 2);
      vec++; if (dv !== 1'b1 || data !== C + 2) begin errs++; $display("FAIL midflush_resp got=%b/%h exp=1/%h", dv, data, C + 2); end
      @(negedge clk);
      issue(32'h0000_2018, 1'b0);
      vec++; if ({ready, dv} !== 2'b00) begin errs++; $display("FAIL midflush_remiss got=%b exp=00", {ready, dv}); end
      grant(f, ma);
      vec++; if (ma !== 32'h0000_2010) begin errs++; $display("FAIL midflush_addr got=%h exp=00002010", ma); end
      beats(C, 0, 4);
      vec++; if (data !== C + 2) begin errs++; $display("FAIL midflush_refill got=%h exp=%h", data, C + 2); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fill;
      logic f; logic [31:0] ma;
      issue(32'h0000_3004, 1'b0);
      grant(f, ma);
      beats(X, 0, 2);
      rst = 1'b0;
      @(negedge clk);
      vec++; if ({ready, dv, mem_req_valid} !== 3'b000) begin errs++; $display("FAIL rstfill_outs got=%b exp=000", {ready, dv, mem_req_valid}); end
      rst = 1'b1;
      beats(X, 2, 2);
      vec++; if ({ready, dv, mem_req_valid} !== 3'b100) begin errs++; $display("FAIL rstfill_stray got=%b exp=100", {ready, dv, mem_req_valid}); end
      issue(32'h0000_3004, 1'b0);
      vec++; if ({ready, dv} !== 2'b00) begin errs++; $display("FAIL rstfill_miss got=%b exp=00", {ready, dv}); end
      grant(f, ma);
      vec++; if (f !== 1'b1 || ma !== 32'h0000_3000) begin errs++; $display("FAIL rstfill_mreq got=%b/%h exp=1/00003000", f, ma); end
      beats(D, 0, 4);
      vec++; if (dv !== 1'b1 || data !== D + 1) begin errs++; $display("FAIL rstfill_resp got=%b/%h exp=1/%h", dv, data, D + 1); end
      @(negedge clk);
      issue(32'h0000_300C, 1'b0);
      vec++; if (dv !== 1'b1 || data !== D + 3) begin errs++; $display("FAIL rstfill_hit got=%b/%h exp=1/%h", dv, data, D + 3); end
      @(negedge clk);
   endtask

   task automatic test_write_drop;
      issue(32'h0000_3004, 1'b1);
      vec++; if ({ready, dv, mem_req_valid} !== 3'b100) begin errs++; $display("FAIL wen_drop got=%b exp=100", {ready, dv, mem_req_valid}); end
      @(negedge clk);
      vec++; if ({ready, dv, mem_req_valid} !== 3'b100) begin errs++; $display("FAIL wen_idle got=%b exp=100", {ready, dv, mem_req_valid}); end
      issue(32'h0000_2000, 1'b1);
      vec++; if ({ready, dv, mem_req_valid} !== 3'b100) begin errs++; $display("FAIL wen_nomiss got=%b exp=100", {ready, dv, mem_req_valid}); end
      @(negedge clk);
   endtask

   task automatic test_last_index;
      logic f; logic [31:0] ma;
      issue(32'h0000_03F4, 1'b0);
      grant(f, ma);
      vec++; if (ma !== 32'h0000_03F0) begin errs++; $display("FAIL lastidx_addr got=%h exp=000003F0", ma); end
      beats(E, 0, 4);
      vec++; if (data !== E + 1) begin errs++; $display("FAIL lastidx_resp got=%h exp=%h", data, E + 1); end
      @(negedge clk);
      issue(32'h0000_03F8, 1'b0);
      vec++; if (dv !== 1'b1 || data !== E + 2) begin errs++; $display("FAIL lastidx_hit got=%b/%h exp=1/%h", dv, data, E + 2); end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; wen = 1'b0; addr = '0; flush = 1'b0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      @(negedge clk);
      test_reset;
      test_cold_miss;
      test_back_to_back;
      test_conflict;
      test_flush;
      test_reset_mid_fill;
      test_write_drop;
      test_last_index;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
